// File: rtl/gb_alu.sv
// SM83-style 8-bit ALU: ADD/ADC/SUB/SBC/AND/OR/XOR/CP with Z/N/H/C flags.
// Result and flags are captured on an enabled rising edge (one cycle latency).
module gb_alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] num1,
   input  logic [7:0] num2,
   input  logic [2:0] cmd,
   input  logic       carry_in,
   output logic [7:0] out,
   output logic       flag_zero,
   output logic       flag_sub,
   output logic       flag_half_carry,
   output logic       flag_carry
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_ADC = 3'b001,
      OP_SUB = 3'b010,
      OP_SBC = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_CP  = 3'b111
   } opcode_t;

   opcode_t    op;
   logic       c;
   logic [8:0] sum9;
   logic [4:0] hsum;
   logic [8:0] sub_rhs;
   logic [4:0] hsub_rhs;
   logic [7:0] diff;
   logic       borrow;
   logic       hborrow;

   logic [7:0] res_nxt;
   logic [7:0] zsrc;
   logic       n_nxt;
   logic       h_nxt;
   logic       c_nxt;

   assign op = opcode_t'(cmd);

   always_comb begin
      c        = ((op == OP_ADC) || (op == OP_SBC)) ? carry_in : 1'b0;
      sum9     = {1'b0, num1} + {1'b0, num2} + {8'b0, c};
      hsum     = {1'b0, num1[3:0]} + {1'b0, num2[3:0]} + {4'b0, c};
      sub_rhs  = {1'b0, num2} + {8'b0, c};
      hsub_rhs = {1'b0, num2[3:0]} + {4'b0, c};
      diff     = num1 - num2 - {7'b0, c};
      borrow   = {1'b0, num1} < sub_rhs;
      hborrow  = {1'b0, num1[3:0]} < hsub_rhs;
   end

   always_comb begin
      res_nxt = 8'h00;
      zsrc    = 8'h00;
      n_nxt   = 1'b0;
      h_nxt   = 1'b0;
      c_nxt   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            res_nxt = sum9[7:0];
            zsrc    = sum9[7:0];
            h_nxt   = hsum[4];
            c_nxt   = sum9[8];
         end
         OP_SUB, OP_SBC: begin
            res_nxt = diff;
            zsrc    = diff;
            n_nxt   = 1'b1;
            h_nxt   = hborrow;
            c_nxt   = borrow;
         end
         OP_AND: begin
            res_nxt = num1 & num2;
            zsrc    = res_nxt;
            h_nxt   = 1'b1;
         end
         OP_OR: begin
            res_nxt = num1 | num2;
            zsrc    = res_nxt;
         end
         OP_XOR: begin
            res_nxt = num1 ^ num2;
            zsrc    = res_nxt;
         end
         OP_CP: begin
            // accumulator passes through; flags come from the discarded difference
            res_nxt = num1;
            zsrc    = diff;
            n_nxt   = 1'b1;
            h_nxt   = hborrow;
            c_nxt   = borrow;
         end
         default: begin
            res_nxt = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out             <= 8'h00;
         flag_zero       <= 1'b0;
         flag_sub        <= 1'b0;
         flag_half_carry <= 1'b0;
         flag_carry      <= 1'b0;
      end else if (en) begin
         out             <= res_nxt;
         flag_zero       <= (zsrc == 8'h00);
         flag_sub        <= n_nxt;
         flag_half_carry <= h_nxt;
         flag_carry      <= c_nxt;
      end
   end

endmodule

// File: tb/tb_gb_alu.sv
// Testbench for gb_alu: directed vector table, reset/hold sequences and
// random vectors checked through an expected-result queue.
module tb_gb_alu;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [2:0] cmd;
   logic       carry_in;
   logic [7:0] out;
   logic       flag_zero;
   logic       flag_sub;
   logic       flag_half_carry;
   logic       flag_carry;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic       cin;
      logic [7:0] eout;
      logic [3:0] eflags;   // {Z,N,H,C}
   } vec_t;

   typedef struct {
      logic [7:0] eout;
      logic [3:0] eflags;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[18];

   gb_alu dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .num1(num1),
      .num2(num2),
      .cmd(cmd),
      .carry_in(carry_in),
      .out(out),
      .flag_zero(flag_zero),
      .flag_sub(flag_sub),
      .flag_half_carry(flag_half_carry),
      .flag_carry(flag_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [7:0] eout, input logic [3:0] eflags);
      logic [3:0] aflags;
      aflags = {flag_zero, flag_sub, flag_half_carry, flag_carry};
      n_checks++;
      if (out !== eout) begin
         n_fail++;
         $display("FAIL %s out: got %02h expected %02h", name, out, eout);
      end
      n_checks++;
      if (aflags !== eflags) begin
         n_fail++;
         $display("FAIL %s flags ZNHC: got %04b expected %04b", name, aflags, eflags);
      end
   endtask

   // Independent reference using plain integer arithmetic.
   function automatic logic [11:0] model(input logic [7:0] a8, input logic [7:0] b8,
                                         input logic [2:0] op, input logic cin);
      int a, b, c, r, o, z, n, h, cy;
      a = a8; b = b8;
      c = (op == 3'd1 || op == 3'd3) ? int'(cin) : 0;
      o = 0; z = 0; n = 0; h = 0; cy = 0;
      case (op)
         3'd0, 3'd1: begin
            r = a + b + c; o = r % 256; cy = (r > 255); h = ((a % 16) + (b % 16) + c) > 15;
            z = (o == 0);
         end
         3'd2, 3'd3, 3'd7: begin
            r = a - b - c; n = 1; cy = (r < 0); h = ((a % 16) - (b % 16) - c) < 0;
            o = (r + 256) % 256; z = (o == 0);
            if (op == 3'd7) o = a;
         end
         3'd4: begin o = a & b; h = 1; z = (o == 0); end
         3'd5: begin o = a | b; z = (o == 0); end
         default: begin o = a ^ b; z = (o == 0); end
      endcase
      return {o[7:0], z[0], n[0], h[0], cy[0]};
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic cin, input logic [7:0] eout, input logic [3:0] eflags,
                        input string name);
      exp_t e;
      @(negedge clk);
      num1 = a; num2 = b; cmd = op; carry_in = cin; en = 1'b1;
      e.eout = eout; e.eflags = eflags; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic collect();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard: queue empty, got %02h expected an entry", out);
      end else begin
         e = exp_q.pop_front();
         check(e.name, e.eout, e.eflags);
      end
   endtask

   initial begin
      logic [11:0] m;
      logic [7:0]  ra, rb;
      logic [2:0]  rop;
      logic        rcin;

      vecs[0]  = '{8'd15, 8'd10, 3'b000, 1'b0, 8'h19, 4'b0010};
      vecs[1]  = '{8'd20, 8'd5,  3'b010, 1'b0, 8'h0F, 4'b0110};
      vecs[2]  = '{8'h00, 8'h00, 3'b011, 1'b1, 8'hFF, 4'b0111};
      vecs[3]  = '{8'hFF, 8'h0F, 3'b100, 1'b0, 8'h0F, 4'b0010};
      vecs[4]  = '{8'hF0, 8'h0F, 3'b101, 1'b0, 8'hFF, 4'b0000};
      vecs[5]  = '{8'hAA, 8'h55, 3'b110, 1'b0, 8'hFF, 4'b0000};
      vecs[6]  = '{8'd30, 8'd30, 3'b111, 1'b0, 8'd30, 4'b1100};
      vecs[7]  = '{8'h10, 8'h20, 3'b111, 1'b0, 8'h10, 4'b0101};
      vecs[8]  = '{8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 4'b1011};
      vecs[9]  = '{8'hFF, 8'h01, 3'b001, 1'b1, 8'h01, 4'b0011};
      vecs[10] = '{8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 4'b1011};
      vecs[11] = '{8'h5A, 8'h5A, 3'b110, 1'b1, 8'h00, 4'b1000};
      vecs[12] = '{8'h10, 8'h10, 3'b010, 1'b1, 8'h00, 4'b1100};
      vecs[13] = '{8'h10, 8'h0F, 3'b011, 1'b1, 8'h00, 4'b1110};
      vecs[14] = '{8'h00, 8'hFF, 3'b100, 1'b1, 8'h00, 4'b1010};
      vecs[15] = '{8'h05, 8'h06, 3'b111, 1'b1, 8'h05, 4'b0111};
      vecs[16] = '{8'h08, 8'h07, 3'b001, 1'b1, 8'h10, 4'b0010};
      vecs[17] = '{8'h00, 8'h00, 3'b101, 1'b0, 8'h00, 4'b1000};

      rst_n = 1'b0; en = 1'b1; num1 = 8'h5C; num2 = 8'hA3; cmd = 3'b000; carry_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("reset_held", 8'h00, 4'b0000);

      // load a non-zero value, then assert reset between edges
      @(negedge clk) rst_n = 1'b1;
      drive(8'd15, 8'd10, 3'b000, 1'b0, 8'h19, 4'b0010, "first_after_reset");
      collect();
      #2 rst_n = 1'b0;
      #1 check("async_reset", 8'h00, 4'b0000);

      // pending enabled result discarded by reset across an edge
      @(negedge clk);
      num1 = 8'hFF; num2 = 8'h01; cmd = 3'b000; en = 1'b1;
      @(posedge clk);
      #1 check("reset_discards", 8'h00, 4'b0000);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].eout, vecs[i].eflags,
               $sformatf("vec%0d", i));
         collect();
      end

      // hold: en low keeps the last result while inputs change
      drive(8'd20, 8'd5, 3'b010, 1'b0, 8'h0F, 4'b0110, "hold_load");
      collect();
      @(negedge clk);
      en = 1'b0; num1 = 8'hFF; num2 = 8'h01; cmd = 3'b000; carry_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 check($sformatf("hold%0d", k), 8'h0F, 4'b0110);
      end
      drive(8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 4'b1011, "hold_release");
      collect();

      for (int i = 0; i < 60; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rop = 3'($urandom_range(0, 7));
         rcin = 1'($urandom_range(0, 1));
         m = model(ra, rb, rop, rcin);
         drive(ra, rb, rop, rcin, m[11:4], m[3:0], $sformatf("rand%0d", i));
         collect();
      end

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gb_alu.md
Name: gb_alu

Overview:
- 8-bit Game Boy (SM83-style) arithmetic/logic unit for the CPU datapath.
- Performs ADD, ADC, SUB, SBC, AND, OR, XOR and CP on two byte operands, selected by a 3-bit opcode.
- Produces a result byte plus Z, N, H and C flags.
- Result and flags are registered, with one clock of latency.

Parameters:
- none. Width is fixed at 8 bits.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  capture enable; when high, registers load the new result
- num1  in  8  operand A (accumulator side)
- num2  in  8  operand B
- cmd  in  3  opcode: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 CP
- carry_in  in  1  incoming C flag; used only by ADC/SBC
- out  out  8  registered result
- flag_zero  out  1  registered Z
- flag_sub  out  1  registered N
- flag_half_carry  out  1  registered H
- flag_carry  out  1  registered C

Behaviour:
- Reset: rst_n low asynchronously forces out, flag_zero, flag_sub, flag_half_carry and flag_carry to 0. They stay 0 while rst_n is low.
- Timing:
  - On a rising clk with rst_n high and en high, all five outputs load values computed combinationally from the current num1, num2, cmd and carry_in.
  - Latency is exactly 1 cycle.
  - With en low, outputs hold their previous value.
- Arithmetic: c = carry_in for ADC/SBC, otherwise 0.
- ADD/ADC:
  - sum9 = num1 + num2 + c (9-bit); out = sum9[7:0]; C = sum9[8].
  - H = carry out of bit 3, i.e. (num1[3:0] + num2[3:0] + c) > 15.
  - N = 0.
- SUB/SBC:
  - diff = num1 - num2 - c modulo 256; out = diff.
  - C = 1 if num1 < num2 + c, computed as a 9-bit compare.
  - H = 1 if num1[3:0] < num2[3:0] + c.
  - N = 1.
- AND: out = num1 & num2; N = 0, H = 1, C = 0.
- OR: out = num1 | num2; N = 0, H = 0, C = 0.
- XOR: out = num1 ^ num2; N = 0, H = 0, C = 0.
- CP:
  - Flags are computed exactly as SUB with c = 0.
  - out = num1 unchanged, so the accumulator is not modified.
  - Z reflects the subtraction result, not out.
- Z = 1 when the 8-bit operation result is zero; for CP, when num1 == num2.
- Carry_in is ignored for every opcode except ADC and SBC.
- Wrap-around is modulo 256 with no saturation. Overflow/underflow is reported only through C.
- Reset asserted mid-operation discards the pending result. The first enabled edge after rst_n rises loads fresh values.
- No X propagation on legal inputs. All opcodes are defined, so there is no illegal-opcode case.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all outputs 0 immediately, without waiting for a clock. Release, then num1=15, num2=10, cmd=000, en=1 -> after 1 clk: out=25 (0x19), Z=0, N=0, H=1, C=0.
- Subtract: num1=20, num2=5, cmd=010 -> out=15 (0x0F), Z=0, N=1, H=1, C=0. Then num1=0x00, num2=0x00, carry_in=1, cmd=011 -> out=0xFF, Z=0, N=1, H=1, C=1.
- Logic: num1=0xFF, num2=0x0F, cmd=100 -> out=0x0F, H=1, C=0. num1=0xF0, num2=0x0F, cmd=101 -> out=0xFF, all flags 0. num1=0xAA, num2=0x55, cmd=110 -> out=0xFF, all flags 0.
- Compare: num1=30, num2=30, cmd=111 -> out=30, Z=1, N=1, H=0, C=0. num1=0x10, num2=0x20, cmd=111 -> out=0x10, Z=0, N=1, H=0, C=1.
- Wrap: num1=0xFF, num2=0x01, cmd=000 -> out=0x00, Z=1, H=1, C=1. Repeat with cmd=001, carry_in=1 -> out=0x01, Z=0, H=1, C=1. Also cmd=000 with carry_in=1 -> carry_in ignored, out=0x00.
- Hold: after a result is loaded, drop en and change all inputs -> outputs unchanged for 3 clocks. Raise en -> new result 1 clk later.
